fix_point_mul_arbiter: RTL

Shares one pipelined signed fixed-point multiplier among NUM_REQ requesters (ball-physics update units: velocity scaling, friction, collision response). Each requester has a valid/ready request port. The arbiter grants at most one request per cycle, pushes it through a PIPE_STAGES-deep registered multiply pipeline, and returns the result on a single tagged output with backpressure. The multiply arithmetic is bit-identical to the team's combinational fix_point_multiply, which this block instantiates.

---
 rtl/fix_point_mul_arbiter.sv | 233 +++++++++++++++++++++++
 1 files changed

// File: rtl/fix_point_mul_arbiter.sv
// fix_point_mul_arbiter: shares one pipelined signed fixed-point multiplier
// among NUM_REQ requesters. Each request port is granted at most once per
// cycle. Granted operands are multiplied combinationally and then pass through
// a PIPE_STAGES-deep register pipeline. The last stage drives a tagged result
// port that supports backpressure.
//
// Build option: define FIX_MUL_ARB_RR_EN to get round-robin arbitration, which
// uses a rotating pointer. Without it, arbitration is fixed priority (lowest
// index wins) and no pointer register exists.
//
// Handshake semantics (all ports): a transfer happens on a rising clk edge
// when valid and ready are both high. A source that raises valid keeps it and
// its payload stable until the transfer. Ready may depend combinationally on
// valid. The result port is registered: res_valid/res_id/res_data hold while
// res_valid=1 and res_ready=0.

// Combinational signed fixed-point multiply: take the upper WIDTH bits of the
// full 2*WIDTH product, shift left by INT*INT-INT, wrap to WIDTH bits.
module fix_point_multiply #(
  parameter int WIDTH      = 32,
  parameter int FRAC_WIDTH = 30
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result
);

  localparam int INT_WIDTH = WIDTH - FRAC_WIDTH;
  localparam int SHIFT     = INT_WIDTH * INT_WIDTH - INT_WIDTH;

  logic [2*WIDTH-1:0] a_ext;
  logic [2*WIDTH-1:0] b_ext;
  logic [2*WIDTH-1:0] product;
  logic [WIDTH-1:0]   upper;

  // Sign-extend both operands to the full width. The low 2*WIDTH bits of the
  // unsigned product of the extended values then equal the signed product.
  assign a_ext   = {{WIDTH{a[WIDTH-1]}}, a};
  assign b_ext   = {{WIDTH{b[WIDTH-1]}}, b};
  assign product = a_ext * b_ext;
  assign upper   = product[2*WIDTH-1:WIDTH];
  assign result  = upper << SHIFT;

endmodule

module fix_point_mul_arbiter #(
  parameter int WIDTH       = 32,
  parameter int FRAC_WIDTH  = 30,
  parameter int NUM_REQ     = 4,
  parameter int ID_WIDTH    = 2,
  parameter int PIPE_STAGES = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*WIDTH-1:0]   req_x,
  input  logic [NUM_REQ*WIDTH-1:0]   req_y,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [ID_WIDTH-1:0]        res_id,
  output logic [WIDTH-1:0]           res_data,
  output logic                       idle
);

  localparam int LAST = PIPE_STAGES - 1;

  // Pipeline advance enable. When it is low the whole block freezes,
  // including the grant path.
  logic                                adv;
  logic                                grant_any;
  logic [ID_WIDTH-1:0]                 grant_id;
  logic [WIDTH-1:0]                    sel_x;
  logic [WIDTH-1:0]                    sel_y;
  logic [WIDTH-1:0]                    product;

  // Stage 0 is the first register after the multiplier. Stage LAST drives
  // the result port.
  logic [PIPE_STAGES-1:0]              vld_q;
  logic [PIPE_STAGES-1:0]              vld_d;
  logic [PIPE_STAGES-1:0][ID_WIDTH-1:0] id_q;
  logic [PIPE_STAGES-1:0][ID_WIDTH-1:0] id_d;
  logic [PIPE_STAGES-1:0][WIDTH-1:0]    data_q;
  logic [PIPE_STAGES-1:0][WIDTH-1:0]    data_d;

  assign res_valid = vld_q[LAST];
  assign res_id    = id_q[LAST];
  assign res_data  = data_q[LAST];
  assign idle      = ~|vld_q;
  assign adv       = !res_valid || res_ready;

`ifdef FIX_MUL_ARB_RR_EN
  // Round-robin pointer: the first index searched on the next grant.
  logic [ID_WIDTH-1:0] ptr_q;
  logic [ID_WIDTH-1:0] ptr_d;
  logic                hi_any;
  logic [ID_WIDTH-1:0] hi_id;
  logic                lo_any;
  logic [ID_WIDTH-1:0] lo_id;

  // Rotating search: the lowest active index at or above ptr wins. If there
  // is none, the lowest active index overall wins (the wrapped part).
  always_comb begin
    hi_any    = 1'b0;
    hi_id     = '0;
    lo_any    = 1'b0;
    lo_id     = '0;
    grant_any = 1'b0;
    grant_id  = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        lo_any = 1'b1;
        lo_id  = ID_WIDTH'(i);
        if (ID_WIDTH'(i) >= ptr_q) begin
          hi_any = 1'b1;
          hi_id  = ID_WIDTH'(i);
        end
      end
    end
    if (hi_any) begin
      grant_any = 1'b1;
      grant_id  = hi_id;
    end else if (lo_any) begin
      grant_any = 1'b1;
      grant_id  = lo_id;
    end
    if (reset || !adv) begin
      grant_any = 1'b0;
      grant_id  = '0;
    end
  end

  // Move the pointer one past the granted requester, wrapping at NUM_REQ.
  always_comb begin
    ptr_d = ptr_q;
    if (grant_any) begin
      if (grant_id == ID_WIDTH'(NUM_REQ - 1)) begin
        ptr_d = '0;
      end else begin
        ptr_d = grant_id + ID_WIDTH'(1);
      end
    end
  end

  // Pointer register.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`else
  // Fixed priority: the lowest active index wins.
  always_comb begin
    grant_any = 1'b0;
    grant_id  = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        grant_any = 1'b1;
        grant_id  = ID_WIDTH'(i);
      end
    end
    if (reset || !adv) begin
      grant_any = 1'b0;
      grant_id  = '0;
    end
  end
`endif

  // One-hot grant. It is only ever set for a requester whose valid is high.
  always_comb begin
    req_ready = '0;
    if (grant_any) begin
      req_ready = NUM_REQ'(1) << grant_id;
    end
  end

  // Select the granted requester's operands for the shared multiplier.
  always_comb begin
    sel_x = '0;
    sel_y = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_id == ID_WIDTH'(i)) begin
        sel_x = req_x[i*WIDTH +: WIDTH];
        sel_y = req_y[i*WIDTH +: WIDTH];
      end
    end
  end

  fix_point_multiply #(
    .WIDTH      (WIDTH),
    .FRAC_WIDTH (FRAC_WIDTH)
  ) u_mul (
    .a      (sel_x),
    .b      (sel_y),
    .result (product)
  );

  // Next pipeline state. On advance, stage 0 captures the grant (or a
  // bubble) and every later stage takes its predecessor's contents.
  always_comb begin
    vld_d  = vld_q;
    id_d   = id_q;
    data_d = data_q;
    if (adv) begin
      vld_d[0] = grant_any;
      if (grant_any) begin
        id_d[0]   = grant_id;
        data_d[0] = product;
      end
      for (int k = 1; k < PIPE_STAGES; k++) begin
        vld_d[k]  = vld_q[k-1];
        id_d[k]   = id_q[k-1];
        data_d[k] = data_q[k-1];
      end
    end
  end

  // Pipeline registers. Reset discards every in-flight entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q  <= '0;
      id_q   <= '0;
      data_q <= '0;
    end else begin
      vld_q  <= vld_d;
      id_q   <= id_d;
      data_q <= data_d;
    end
  end

endmodule
